// File: rtl/nn_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the feature stream,
// the nn core and the result stream.
interface nn_frame_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;

    logic [ADDR_WIDTH-1:0] nn_addr;
    logic [DATA_WIDTH-1:0] nn_data;
    logic                  nn_we;
    logic                  nn_valid;
    logic                  nn_start;
    logic                  nn_rst;
    logic                  nn_done;
    logic [7:0]            nn_class;
    logic [DATA_WIDTH-1:0] nn_rdata;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_score;
    logic [7:0]            m_index;
    logic [7:0]            m_class;
    logic                  m_last;

    modport master (
        input  s_valid, s_data, s_last,
        output s_ready,
        output nn_addr, nn_data, nn_we, nn_valid,
        output nn_start, nn_rst,
        input  nn_done, nn_class, nn_rdata,
        output m_valid, m_score, m_index, m_class, m_last,
        input  m_ready
    );

    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  nn_addr, nn_data, nn_we, nn_valid,
        input  nn_start, nn_rst,
        output nn_done, nn_class, nn_rdata,
        input  m_valid, m_score, m_index, m_class, m_last,
        output m_ready
    );
endinterface

// File: rtl/nn_frame_sequencer.sv
// Loads one feature frame into the nn core, runs it, and streams scores out.
// Optional done watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_frame_sequencer #(
    parameter int NUM_INPUTS     = 8,
    parameter int NUM_OUTPUTS    = 5,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nn_frame_sequencer_if.master bus,
    output logic                 o_busy,
    output logic                 o_error,
    output logic                 o_timeout
);

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_DONE,
        READ,
        CAP,
        OUT,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IN  = ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_OUT = ADDR_WIDTH'(NUM_OUTPUTS - 1);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [DATA_WIDTH-1:0] score_q;
    logic [7:0]            index_q;
    logic [7:0]            class_q;
    logic                  last_q;
    logic                  s_rdy;
    logic                  accept;
    logic                  wr_end;
    logic                  tmo_hit;

    // s_ready is masked while reset is held so the stream sees 0
    assign s_rdy  = reset_n && (state == LOAD || state == DRAIN);
    assign accept = bus.s_valid && s_rdy;
    assign wr_end = (wr_cnt == LAST_IN);

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || state != WAIT_DONE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // a done arriving on the limit cycle still wins
    assign tmo_hit = (state == WAIT_DONE) && !bus.nn_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    // watchdog compiled out; the limit can never be negative
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.nn_valid = 1'b0;
        bus.nn_we    = 1'b0;
        bus.nn_addr  = '0;
        bus.nn_data  = '0;
        bus.nn_start = 1'b0;
        bus.m_valid  = 1'b0;
        o_error      = 1'b0;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    bus.nn_valid = 1'b1;
                    bus.nn_we    = 1'b1;
                    bus.nn_addr  = wr_cnt;
                    bus.nn_data  = bus.s_data;
                    if (wr_end) begin
                        if (bus.s_last) begin
                            state_nx = START;
                        end else begin
                            o_error  = 1'b1;
                            state_nx = DRAIN;
                        end
                    end else if (bus.s_last) begin
                        o_error = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.s_last) begin
                    state_nx = LOAD;
                end
            end
            START: begin
                bus.nn_start = 1'b1;
                state_nx     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.nn_done) begin
                    state_nx = READ;
                end else if (tmo_hit) begin
                    state_nx = LOAD;
                end
            end
            READ: begin
                bus.nn_valid = 1'b1;
                bus.nn_addr  = rd_cnt;
                state_nx     = CAP;
            end
            CAP: begin
                state_nx = OUT;
            end
            OUT: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    state_nx = last_q ? LOAD : READ;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            score_q <= '0;
            index_q <= '0;
            class_q <= '0;
            last_q  <= 1'b0;
        end else begin
            // both frame-length errors and a full frame restart at 0
            if (state == LOAD && accept) begin
                if (wr_end || bus.s_last) begin
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (state == WAIT_DONE && bus.nn_done) begin
                class_q <= bus.nn_class;
                rd_cnt  <= '0;
            end
            if (state == CAP) begin
                score_q <= bus.nn_rdata;
                index_q <= 8'(rd_cnt);
                last_q  <= (rd_cnt == LAST_OUT);
            end
            if (state == OUT && bus.m_ready && !last_q) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    assign bus.s_ready = s_rdy;
    assign bus.m_score = score_q;
    assign bus.m_index = index_q;
    assign bus.m_class = class_q;
    assign bus.m_last  = last_q;
    assign bus.nn_rst  = !reset_n || tmo_hit;
    assign o_busy      = (state != LOAD);
    assign o_timeout   = tmo_hit;

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed bench for nn_frame_sequencer with a small core model.
// Define NN_SEQ_TIMEOUT_EN to exercise the done watchdog.
module tb_nn_frame_sequencer;

    localparam int NI = 4;
    localparam int NO = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic o_busy;
    logic o_error;
    logic o_timeout;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int clash_cnt = 0;
    int tmo_cnt = 0;

    logic [15:0] scores [0:31];
    logic [4:0]  rd_log [$];

    always #5 clk = ~clk;

    nn_frame_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

    nn_frame_sequencer #(
        .NUM_INPUTS    (NI),
        .NUM_OUTPUTS   (NO),
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .o_busy   (o_busy),
        .o_error  (o_error),
        .o_timeout(o_timeout)
    );

    // core model: registered read port plus activity monitors
    always @(posedge clk) begin
        if (bus.nn_valid && !bus.nn_we) begin
            bus.nn_rdata <= scores[bus.nn_addr];
            rd_log.push_back(bus.nn_addr);
        end
        if (bus.nn_start) start_cnt++;
        if (bus.m_valid && bus.nn_valid) clash_cnt++;
        if (o_timeout) tmo_cnt++;
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        dn;
        logic        rdy;
        logic        we;
        logic [4:0]  a;
        logic        err;
        logic        st;
        logic        busy;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_scores(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c);
        scores[0] = a;
        scores[1] = b;
        scores[2] = c;
    endtask

    // one beat per cycle, beat i carries base+i, s_last on last_at
    task automatic send_frame(input int n, input int last_at,
                              input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            logic lst;
            logic we;
            logic err;
            lst = (i == last_at);
            we  = (i < NI);
            err = (i == NI - 1 && !lst) || (lst && i < NI - 1);
            tick();
            bus.s_valid = 1'b1;
            bus.s_data  = base + 16'(i);
            bus.s_last  = lst;
            #1;
            chk("sf_ready", bus.s_ready, 1);
            chk("sf_we", bus.nn_we, we);
            chk("sf_valid", bus.nn_valid, we);
            chk("sf_addr", bus.nn_addr, we ? i : 0);
            chk("sf_data", bus.nn_data, we ? base + 16'(i) : 16'h0);
            chk("sf_error", o_error, err);
            chk("sf_busy", o_busy, i >= NI);
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_start(input int exp_lat);
        int n;
        n = 1;
        #1;
        while (!bus.nn_start && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("start_lat", n, exp_lat);
    endtask

    task automatic give_done(input logic [7:0] cls);
        tick();
        bus.nn_done  = 1'b1;
        bus.nn_class = cls;
        #1;
        chk("done_mvalid", bus.m_valid, 0);
    endtask

    task automatic run_results(input logic [7:0] cls, input int first,
                               input int upto, input int first_lat);
        for (int b = first; b <= upto; b++) begin
            int n;
            n = 0;
            do begin
                tick();
                bus.nn_done  = 1'b0;
                bus.nn_class = 8'hEE;
                #1;
                n++;
            end while (!bus.m_valid && n < 20);
            chk("beat_lat", n, (b == first) ? first_lat : 3);
            chk("m_score", bus.m_score, scores[b]);
            chk("m_index", bus.m_index, b);
            chk("m_class", bus.m_class, cls);
            chk("m_last", bus.m_last, b == NO - 1);
        end
    endtask

    task automatic end_frame();
        tick();
        #1;
        chk("end_ready", bus.s_ready, 1);
        chk("end_busy", o_busy, 0);
        chk("end_mvalid", bus.m_valid, 0);
        chk("reads_n", rd_log.size(), NO);
        for (int i = 0; i < NO; i++) begin
            if (i < rd_log.size()) chk("read_addr", rd_log[i], i);
        end
        rd_log.delete();
    endtask

    initial begin
        int s0;
        tbl[0]  = '{0, 16'h0000, 0, 0, 1, 0, 5'd0, 0, 0, 0};
        tbl[1]  = '{1, 16'h0A00, 0, 0, 1, 1, 5'd0, 0, 0, 0};
        tbl[2]  = '{1, 16'h0B00, 1, 0, 1, 1, 5'd1, 1, 0, 0};
        tbl[3]  = '{0, 16'h0000, 0, 1, 1, 0, 5'd0, 0, 0, 0};
        tbl[4]  = '{1, 16'h0100, 0, 0, 1, 1, 5'd0, 0, 0, 0};
        tbl[5]  = '{1, 16'h0200, 0, 0, 1, 1, 5'd1, 0, 0, 0};
        tbl[6]  = '{0, 16'h0250, 1, 0, 1, 0, 5'd0, 0, 0, 0};
        tbl[7]  = '{1, 16'h0300, 0, 0, 1, 1, 5'd2, 0, 0, 0};
        tbl[8]  = '{1, 16'h0400, 1, 0, 1, 1, 5'd3, 0, 0, 0};
        tbl[9]  = '{1, 16'h7777, 0, 1, 0, 0, 5'd0, 0, 1, 1};
        tbl[10] = '{1, 16'h7777, 1, 0, 0, 0, 5'd0, 0, 0, 1};

        reset_n      = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_last   = 1'b0;
        bus.nn_done  = 1'b0;
        bus.nn_class = 8'd0;
        bus.m_ready  = 1'b1;
        set_scores(16'h0010, 16'h0050, 16'h0030);
        repeat (2) tick();
        @(posedge clk);
        #1;
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_valid", bus.nn_valid, 0);
        chk("rst_start", bus.nn_start, 0);
        chk("rst_mvalid", bus.m_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_error", o_error, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_score", bus.m_score, 0);
        chk("rst_nnrst", bus.nn_rst, 1);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_nnrst", bus.nn_rst, 0);

        // early last frame, ignored done, then a full 4-beat load
        for (int i = 0; i < 11; i++) begin
            tick();
            bus.s_valid  = tbl[i].v;
            bus.s_data   = tbl[i].d;
            bus.s_last   = tbl[i].l;
            bus.nn_done  = tbl[i].dn;
            bus.nn_class = 8'd9;
            #1;
            chk("tb_ready", bus.s_ready, tbl[i].rdy);
            chk("tb_valid", bus.nn_valid, tbl[i].we);
            chk("tb_we", bus.nn_we, tbl[i].we);
            chk("tb_addr", bus.nn_addr, tbl[i].a);
            chk("tb_data", bus.nn_data, tbl[i].we ? tbl[i].d : 16'h0);
            chk("tb_error", o_error, tbl[i].err);
            chk("tb_start", bus.nn_start, tbl[i].st);
            chk("tb_busy", o_busy, tbl[i].busy);
            chk("tb_mvalid", bus.m_valid, 0);
        end
        rd_log.delete();
        give_done(8'd2);
        run_results(8'd2, 0, NO - 1, 3);
        end_frame();

        // late last: error on beat 4, beat 5 dropped, no start
        s0 = start_cnt;
        send_frame(5, 4, 16'h1000);
        repeat (3) begin
            tick();
            #1;
            chk("late_busy", o_busy, 0);
        end
        chk("late_nostart", start_cnt, s0);

        // result backpressure
        set_scores(16'hFFF0, 16'h7FFF, 16'h8000);
        send_frame(NI, NI - 1, 16'h2000);
        wait_start(1);
        give_done(8'd4);
        bus.m_ready = 1'b0;
        run_results(8'd4, 0, 0, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("bp_mvalid", bus.m_valid, 1);
            chk("bp_score", bus.m_score, 16'hFFF0);
            chk("bp_index", bus.m_index, 0);
            chk("bp_class", bus.m_class, 4);
            chk("bp_nnvalid", bus.nn_valid, 0);
        end
        tick();
        bus.m_ready = 1'b1;
        tick();
        #1;
        chk("bp_read", bus.nn_valid, 1);
        chk("bp_raddr", bus.nn_addr, 1);
        chk("bp_rwe", bus.nn_we, 0);
        run_results(8'd4, 1, NO - 1, 2);
        end_frame();

        // reset while waiting for done
        send_frame(NI, NI - 1, 16'h3000);
        wait_start(1);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("mr_nnrst_pre", bus.nn_rst, 1);
        @(posedge clk);
        #1;
        chk("mr_nnrst", bus.nn_rst, 1);
        chk("mr_busy", o_busy, 0);
        chk("mr_ready", bus.s_ready, 0);
        chk("mr_mvalid", bus.m_valid, 0);
        chk("mr_score", bus.m_score, 0);
        chk("mr_index", bus.m_index, 0);
        chk("mr_class", bus.m_class, 0);
        chk("mr_last", bus.m_last, 0);
        chk("mr_nnvalid", bus.nn_valid, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mr_rel_ready", bus.s_ready, 1);
        chk("mr_rel_nnrst", bus.nn_rst, 0);
        set_scores(16'h0123, 16'h0456, 16'h0789);
        send_frame(NI, NI - 1, 16'h4000);
        wait_start(1);
        give_done(8'd1);
        run_results(8'd1, 0, NO - 1, 3);
        end_frame();

        send_frame(NI, NI - 1, 16'h5000);
        wait_start(1);
`ifdef NN_SEQ_TIMEOUT_EN
        begin
            int n;
            n = 0;
            do begin
                tick();
                #1;
                n++;
            end while (!o_timeout && n < 40);
            chk("tmo_lat", n, 17);
            chk("tmo_nnrst", bus.nn_rst, 1);
            tick();
            #1;
            chk("tmo_ready", bus.s_ready, 1);
            chk("tmo_pulse", o_timeout, 0);
            chk("tmo_nnrst_off", bus.nn_rst, 0);
            chk("tmo_busy", o_busy, 0);
            chk("tmo_count", tmo_cnt, 1);
        end
`else
        repeat (40) tick();
        #1;
        chk("wait_busy", o_busy, 1);
        chk("wait_ready", bus.s_ready, 0);
        chk("wait_nnrst", bus.nn_rst, 0);
        chk("wait_tmo", tmo_cnt, 0);
        give_done(8'd3);
        run_results(8'd3, 0, NO - 1, 3);
        end_frame();
`endif

        chk("no_out_access", clash_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/nn_frame_sequencer.md
# nn_frame_sequencer

Sequences the nn inference core for streaming classification. It accepts one feature frame on a valid/ready stream and writes it into the core's input layer, then pulses the core's start and waits for done. It then reads back every output-layer score and emits the scores with the predicted class on a valid/ready result stream. It sits between the feature-extraction front end and the host/UART result path.

## Interface
- NUM_INPUTS, 8: input-layer neurons (frame length in beats)
- NUM_OUTPUTS, 5: output-layer neurons (result beats per frame)
- DATA_WIDTH, 16: feature/score width, signed
- ADDR_WIDTH, 5: core address width, ≥ clog2(max(NUM_INPUTS, NUM_OUTPUTS))
- TIMEOUT_CYCLES, 65535: done watchdog limit (used only with NN_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- s_valid / s_ready  in/out  1  feature stream handshake
- s_data  in  DATA_WIDTH  feature value
- s_last  in  1  final beat of frame
- nn_addr  out  ADDR_WIDTH  core address
- nn_data  out  DATA_WIDTH  core write data
- nn_we  out  1  core write enable
- nn_valid  out  1  core access valid
- nn_start  out  1  core start pulse
- nn_rst  out  1  core reset, active-high
- nn_done  in  1  core done (1 cycle)
- nn_class  in  8  core predicted class, valid only with nn_done
- nn_rdata  in  DATA_WIDTH  core read data, valid 1 cycle after read request
- m_valid / m_ready  out/in  1  result stream handshake
- m_score  out  DATA_WIDTH  output neuron score
- m_index  out  8  output neuron index
- m_class  out  8  predicted class, constant across a frame's beats
- m_last  out  1  asserted with index NUM_OUTPUTS-1
- o_busy  out  1  high in any state except LOAD
- o_error  out  1  one-cycle pulse on frame-length error
- o_timeout  out  1  one-cycle pulse on watchdog expiry

## Operation
States are LOAD, START, WAIT_DONE, READ, CAP, OUT, DRAIN. Reset enters LOAD.
- LOAD: s_ready=1. Each accepted beat drives nn_valid=1, nn_we=1, nn_addr=wr_cnt, nn_data=s_data combinationally in the same cycle, then increments wr_cnt.
  - Accepted beat with wr_cnt=NUM_INPUTS-1 and s_last=1: go to START.
  - Same beat with s_last=0: pulse o_error, go to DRAIN.
  - s_last=1 with wr_cnt<NUM_INPUTS-1 (early last): pulse o_error, wr_cnt←0, stay in LOAD. nn_start is not issued.
- DRAIN: s_ready=1. Beats are discarded and nothing is written to the core. An accepted beat with s_last=1 moves to LOAD with wr_cnt←0.
- START: nn_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on nn_done, m_class←nn_class, rd_cnt←0, go to READ.
- READ: nn_valid=1, nn_we=0, nn_addr=rd_cnt for one cycle, then go to CAP.
- CAP: m_score←nn_rdata, m_index←rd_cnt, m_last←(rd_cnt==NUM_OUTPUTS-1), then go to OUT.
- OUT: m_valid=1. m_score, m_index, m_class and m_last hold stable until m_ready.
  - On handshake with m_last=1: go to LOAD with wr_cnt←0.
  - On handshake otherwise: rd_cnt++, go to READ.
- No core access occurs while in OUT. All output scores are read before any new input is written.
- nn_rst = ~reset_n, ORed with the timeout pulse.

## Timing
- Reset values: s_ready, nn_addr, nn_data, nn_we, nn_valid, nn_start, m_valid, m_score, m_index, m_class, m_last, o_busy, o_error and o_timeout are all 0. nn_rst is 1 while reset_n=0.
- reset_n low in any state: reset values apply from the next edge and counters clear. The core is reset alongside the sequencer.
- Last input beat accepted at cycle T: nn_start is high at T+1.
- nn_done at cycle D: first m_valid at D+3. With m_ready held high, one result beat completes every 3 cycles.
- s_valid is ignored outside LOAD and DRAIN (s_ready=0).
- nn_done outside WAIT_DONE is ignored.

## Configuration
- NN_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE and clears on entry.
  - When it reaches TIMEOUT_CYCLES without nn_done: pulse o_timeout and nn_rst for one cycle, go to LOAD with wr_cnt←0.
- Undefined: WAIT_DONE waits indefinitely. o_timeout is tied 0 and nn_rst=~reset_n.

## Test plan
- Nominal frame: NUM_INPUTS=4, NUM_OUTPUTS=3. Send 0x0100, 0x0200, 0x0300, 0x0400 with s_last on beat 4. Core model returns done with class 2 and scores 0x0010, 0x0050, 0x0030.
  - Writes appear at addr 0–3.
  - nn_start is high one cycle after the last beat.
  - Three beats follow: index 0/1/2, m_class=2, m_last only on index 2.
- Early last: s_last on beat 2 → o_error pulses once, no nn_start. The next 4-beat frame is processed normally from addr 0.
- Late last: 5 beats with s_last on beat 5 → o_error pulses on beat 4. Beat 5 is not written and no nn_start is issued.
- Backpressure: m_ready low for 10 cycles in OUT → m_score, m_index and m_class are stable and nn_valid stays 0. Release → next READ follows.
- Timeout (macro defined, TIMEOUT_CYCLES=16): core never asserts done → o_timeout and nn_rst pulse 16 cycles after entering WAIT_DONE, and s_ready=1 on the following cycle.
- Reset mid-WAIT_DONE: reset_n low for 1 cycle → all outputs at reset values and nn_rst=1 that cycle. The next frame completes with correct results.
